// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and the 16-word data memory.
// Accepts one LDR/STR/LDM/STM request, moves one word per cycle, returns
// loaded words to the register file and reports the updated base address.
//
// state | meaning
// IDLE  | ready for a request
// XFER  | one word transfer per cycle, lowest register first
// DONE  | one-cycle completion, base writeback
module load_store_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [15:0]       req_reglist,
  input  logic              req_up,
  input  logic              req_wb,
  input  logic [3:0]        req_rn,
  output logic [3:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ldr_str_en,
  output logic              mem_load_en,
  output logic              mem_store_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [3:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              base_we,
  output logic [ADDR_W-1:0] base_wdata,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   final_q;
  logic                load_q, wb_q, rn_hit_q;
  logic                ld_valid_q;
  logic [3:0]          ld_wa_q;
  logic [DATA_W-1:0]   ld_data_q;

  logic [4:0]          cnt;
  logic [ADDR_W-1:0]   cnt_a, start_addr, final_addr;
  logic [3:0]          cur_reg;
  logic                accept;

  // Number of registers in the incoming mask.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(req_reglist[i]);
  end

  // Block spans [start_addr, start_addr+count); all arithmetic wraps mod 2^ADDR_W.
  assign cnt_a      = ADDR_W'(cnt);
  assign start_addr = req_up ? req_base : req_base - cnt_a + ADDR_W'(1);
  assign final_addr = req_up ? req_base + cnt_a : req_base - cnt_a;
  assign accept     = req_valid && (state_q == IDLE);

  // Lowest pending register index.
  always_comb begin
    cur_reg = '0;
    for (int i = 15; i >= 0; i--) if (mask_q[i]) cur_reg = 4'(i);
  end

  // Next state, transfer bookkeeping and strobes.
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    addr_d         = addr_q;
    req_ready      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    mem_ldr_str_en = 1'b0;
    mem_load_en    = 1'b0;
    mem_store_en   = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    rf_rd_addr     = '0;
    base_we        = 1'b0;
    base_wdata     = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mask_d  = req_reglist;
          addr_d  = start_addr;
          state_d = (cnt == 5'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        busy           = 1'b1;
        mem_ldr_str_en = 1'b1;
        mem_addr       = addr_q;
        if (load_q) begin
          mem_load_en = 1'b1;
        end else begin
          mem_store_en = 1'b1;
          rf_rd_addr   = cur_reg;
          mem_wdata    = rf_rd_data;
        end
        mask_d = mask_q & (mask_q - 16'd1);
        addr_d = addr_q + ADDR_W'(1);
        if (mask_d == 16'd0) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        // A load that overwrites the base register takes priority over writeback.
        base_we    = wb_q && !rn_hit_q;
        base_wdata = final_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, mask and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
    end
  end

  // Request fields latched on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= 1'b0;
      wb_q     <= 1'b0;
      rn_hit_q <= 1'b0;
      final_q  <= '0;
    end else if (accept) begin
      load_q   <= req_load;
      wb_q     <= req_wb;
      rn_hit_q <= req_load && req_reglist[req_rn];
      final_q  <= final_addr;
    end
  end

  // Loaded word is registered and written back to the RF the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid_q <= 1'b0;
      ld_wa_q    <= '0;
      ld_data_q  <= '0;
    end else if (state_q == XFER && load_q) begin
      ld_valid_q <= 1'b1;
      ld_wa_q    <= cur_reg;
      ld_data_q  <= mem_rdata;
    end else begin
      ld_valid_q <= 1'b0;
      ld_wa_q    <= '0;
      ld_data_q  <= '0;
    end
  end

  assign rf_we = ld_valid_q;
  assign rf_wa = ld_wa_q;
  assign rf_wd = ld_data_q;

endmodule
